// File: rtl/rf_pkg.sv
// Shared types and constants for the integer register file writeback path.
package rf_pkg;
    localparam int REGISTER_WIDTH   = 64;
    localparam int REGISTERNO_WIDTH = 5;
    localparam int NUM_REGS         = 32;

    typedef logic [REGISTERNO_WIDTH-1:0] regno_t;
    typedef logic [REGISTER_WIDTH-1:0]   regval_t;

    localparam regno_t REG_ZERO = '0;

    typedef enum logic {WB_ALU, WB_LD} wb_src_e;

    typedef struct packed {
        regno_t  rd;
        regval_t value;
    } wb_req_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never busy.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   set_valid,
    input  regno_t set_regno,
    input  logic   clr_valid,
    input  regno_t clr_regno,
    input  regno_t rs1_regno,
    input  regno_t rs2_regno,
    input  regno_t rd_regno,
    output logic   busy_rs1,
    output logic   busy_rs2,
    output logic   busy_rd,
    output logic   any_pending
);
    logic [NUM_REGS-1:0] pending;

    function automatic logic is_busy(input logic [NUM_REGS-1:0] vec, input regno_t r);
        return (r != REG_ZERO) && vec[r];
    endfunction

    assign busy_rs1    = is_busy(pending, rs1_regno);
    assign busy_rs2    = is_busy(pending, rs2_regno);
    assign busy_rd     = is_busy(pending, rd_regno);
    assign any_pending = |pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (clr_valid) begin
                assert (pending[clr_regno])
                    else $warning("writeback to non-pending register x%0d", clr_regno);
                pending[clr_regno] <= 1'b0;
            end
            // A busy rd stalls issue, so set and clear never target the same bit.
            if (set_valid) begin
                assert (!(clr_valid && clr_regno == set_regno))
                    else $error("scoreboard set and clear collide on x%0d", set_regno);
                pending[set_regno] <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates ALU and load writebacks onto the single register file write port
// and stalls issue on RAW/WAW hazards against in-flight destinations.
module regfile_wb_scheduler
    import rf_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    in_alu_valid,
    input  regno_t  in_alu_rd_regno,
    input  regval_t in_alu_rd_value,
    output logic    out_alu_ready,
    input  logic    in_ld_valid,
    input  regno_t  in_ld_rd_regno,
    input  regval_t in_ld_rd_value,
    output logic    out_ld_ready,
    input  logic    in_issue_valid,
    input  regno_t  in_issue_rs1_regno,
    input  regno_t  in_issue_rs2_regno,
    input  regno_t  in_issue_rd_regno,
    output logic    out_issue_stall,
    output logic    out_wr_enable,
    output regno_t  out_rd_regno,
    output regval_t out_rd_value,
    output logic    out_idle
);
    wb_src_e last_grant;
    logic    alu_grant;
    logic    ld_grant;
    logic    grant;
    wb_req_t winner;
    logic    busy_rs1, busy_rs2, busy_rd, any_pending;
    logic    issue_accept;

    // Round-robin: on a conflict the source that did not win last time goes first.
    always_comb begin
        alu_grant = !reset && in_alu_valid && (!in_ld_valid || last_grant == WB_LD);
        ld_grant  = !reset && in_ld_valid && !alu_grant;
        grant     = alu_grant || ld_grant;
        winner    = alu_grant ? '{rd: in_alu_rd_regno, value: in_alu_rd_value}
                              : '{rd: in_ld_rd_regno,  value: in_ld_rd_value};
    end

    assign out_alu_ready   = alu_grant;
    assign out_ld_ready    = ld_grant;
    assign out_issue_stall = in_issue_valid && (busy_rs1 || busy_rs2 || busy_rd);
    assign issue_accept    = in_issue_valid && !out_issue_stall && (in_issue_rd_regno != REG_ZERO);
    assign out_idle        = !any_pending && !out_wr_enable;

    rf_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .set_valid   (issue_accept),
        .set_regno   (in_issue_rd_regno),
        .clr_valid   (out_wr_enable),
        .clr_regno   (out_rd_regno),
        .rs1_regno   (in_issue_rs1_regno),
        .rs2_regno   (in_issue_rs2_regno),
        .rd_regno    (in_issue_rd_regno),
        .busy_rs1    (busy_rs1),
        .busy_rs2    (busy_rs2),
        .busy_rd     (busy_rd),
        .any_pending (any_pending)
    );

    // Write port register: an accepted request appears for exactly the next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_wr_enable <= 1'b0;
            out_rd_regno  <= '0;
            out_rd_value  <= '0;
            last_grant    <= WB_LD;
        end else begin
            out_wr_enable <= grant && (winner.rd != REG_ZERO);
            if (grant) begin
                out_rd_regno <= winner.rd;
                out_rd_value <= winner.value;
                last_grant   <= alu_grant ? WB_ALU : WB_LD;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with hand-computed expectations.
module tb_regfile_wb_scheduler;
    import rf_pkg::*;

    logic    clk = 1'b0;
    logic    reset;
    logic    in_alu_valid;
    regno_t  in_alu_rd_regno;
    regval_t in_alu_rd_value;
    logic    out_alu_ready;
    logic    in_ld_valid;
    regno_t  in_ld_rd_regno;
    regval_t in_ld_rd_value;
    logic    out_ld_ready;
    logic    in_issue_valid;
    regno_t  in_issue_rs1_regno;
    regno_t  in_issue_rs2_regno;
    regno_t  in_issue_rd_regno;
    logic    out_issue_stall;
    logic    out_wr_enable;
    regno_t  out_rd_regno;
    regval_t out_rd_value;
    logic    out_idle;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_wb_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .in_alu_valid       (in_alu_valid),
        .in_alu_rd_regno    (in_alu_rd_regno),
        .in_alu_rd_value    (in_alu_rd_value),
        .out_alu_ready      (out_alu_ready),
        .in_ld_valid        (in_ld_valid),
        .in_ld_rd_regno     (in_ld_rd_regno),
        .in_ld_rd_value     (in_ld_rd_value),
        .out_ld_ready       (out_ld_ready),
        .in_issue_valid     (in_issue_valid),
        .in_issue_rs1_regno (in_issue_rs1_regno),
        .in_issue_rs2_regno (in_issue_rs2_regno),
        .in_issue_rd_regno  (in_issue_rd_regno),
        .out_issue_stall    (out_issue_stall),
        .out_wr_enable      (out_wr_enable),
        .out_rd_regno       (out_rd_regno),
        .out_rd_value       (out_rd_value),
        .out_idle           (out_idle)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input regno_t rs1, input regno_t rs2, input regno_t rd);
        in_issue_valid     = 1'b1;
        in_issue_rs1_regno = rs1;
        in_issue_rs2_regno = rs2;
        in_issue_rd_regno  = rd;
        #1;
        check("issue_no_stall", out_issue_stall, 1'b0);
        step();
        in_issue_valid = 1'b0;
    endtask

    task automatic alu(input logic v, input regno_t rd, input regval_t val);
        in_alu_valid    = v;
        in_alu_rd_regno = rd;
        in_alu_rd_value = val;
    endtask

    task automatic ld(input logic v, input regno_t rd, input regval_t val);
        in_ld_valid    = v;
        in_ld_rd_regno = rd;
        in_ld_rd_value = val;
    endtask

    task automatic expect_write(input string tag, input logic en, input regno_t rd, input regval_t val);
        check({tag, "_wr_enable"}, out_wr_enable, en);
        if (en) begin
            check({tag, "_rd_regno"}, out_rd_regno, rd);
            check({tag, "_rd_value"}, out_rd_value, val);
        end
    endtask

    initial begin
        reset = 1'b1;
        alu(1'b0, '0, '0);
        ld(1'b0, '0, '0);
        in_issue_valid     = 1'b0;
        in_issue_rs1_regno = '0;
        in_issue_rs2_regno = '0;
        in_issue_rd_regno  = '0;
        step();
        step();
        reset = 1'b0;
        step();
        check("post_reset_wr_enable", out_wr_enable, 1'b0);
        check("post_reset_rd_regno", out_rd_regno, 5'd0);
        check("post_reset_rd_value", out_rd_value, 64'd0);
        check("post_reset_idle", out_idle, 1'b1);

        // Reset mid-cycle while a write is on the port and another request is valid.
        issue(5'd0, 5'd0, 5'd2);
        check("idle_after_issue", out_idle, 1'b0);
        alu(1'b1, 5'd2, 64'hAA);
        #1;
        check("rst_alu_ready_pre", out_alu_ready, 1'b1);
        step();
        expect_write("rst_pre", 1'b1, 5'd2, 64'hAA);
        reset = 1'b1;
        #1;
        check("rst_async_wr_enable", out_wr_enable, 1'b0);
        check("rst_async_rd_regno", out_rd_regno, 5'd0);
        check("rst_async_rd_value", out_rd_value, 64'd0);
        check("rst_async_idle", out_idle, 1'b1);
        check("rst_async_alu_ready", out_alu_ready, 1'b0);
        step();
        step();
        alu(1'b0, '0, '0);
        reset = 1'b0;
        step();
        check("rst_release_wr_enable", out_wr_enable, 1'b0);
        check("rst_release_idle", out_idle, 1'b1);

        // Conflict round-robin: ALU wins first after reset.
        issue(5'd0, 5'd0, 5'd3);
        issue(5'd0, 5'd0, 5'd7);
        issue(5'd0, 5'd0, 5'd4);
        alu(1'b1, 5'd3, 64'h33);
        ld(1'b1, 5'd4, 64'h44);
        #1;
        check("rr1_alu_ready", out_alu_ready, 1'b1);
        check("rr1_ld_ready", out_ld_ready, 1'b0);
        step();
        expect_write("rr1", 1'b1, 5'd3, 64'h33);
        alu(1'b1, 5'd7, 64'h77);
        #1;
        check("rr2_alu_ready", out_alu_ready, 1'b0);
        check("rr2_ld_ready", out_ld_ready, 1'b1);
        step();
        expect_write("rr2", 1'b1, 5'd4, 64'h44);
        ld(1'b1, 5'd0, 64'h99);
        #1;
        check("rr3_alu_ready", out_alu_ready, 1'b1);
        check("rr3_ld_ready", out_ld_ready, 1'b0);
        step();
        expect_write("rr3", 1'b1, 5'd7, 64'h77);
        alu(1'b0, '0, '0);
        #1;
        check("rr4_ld_x0_ready", out_ld_ready, 1'b1);
        step();
        ld(1'b0, '0, '0);
        check("rr4_x0_wr_enable", out_wr_enable, 1'b0);
        check("rr_idle", out_idle, 1'b1);

        // Single ALU write.
        issue(5'd0, 5'd0, 5'd5);
        alu(1'b1, 5'd5, 64'h1234);
        #1;
        check("single_alu_ready", out_alu_ready, 1'b1);
        check("single_ld_ready", out_ld_ready, 1'b0);
        step();
        alu(1'b0, '0, '0);
        expect_write("single", 1'b1, 5'd5, 64'h1234);
        check("single_idle_during_write", out_idle, 1'b0);
        step();
        check("single_wr_enable_after", out_wr_enable, 1'b0);
        check("single_idle_after", out_idle, 1'b1);

        // RAW / WAW hazards against pending x6.
        issue(5'd0, 5'd0, 5'd6);
        in_issue_valid     = 1'b1;
        in_issue_rs1_regno = 5'd6;
        in_issue_rs2_regno = 5'd0;
        in_issue_rd_regno  = 5'd0;
        #1;
        check("raw_rs1_stall", out_issue_stall, 1'b1);
        step();
        check("raw_rs1_stall_held", out_issue_stall, 1'b1);
        in_issue_rs1_regno = 5'd0;
        in_issue_rs2_regno = 5'd6;
        #1;
        check("raw_rs2_stall", out_issue_stall, 1'b1);
        in_issue_rs2_regno = 5'd0;
        in_issue_rd_regno  = 5'd6;
        #1;
        check("waw_stall", out_issue_stall, 1'b1);
        in_issue_rd_regno = 5'd0;
        #1;
        check("x0_no_stall", out_issue_stall, 1'b0);
        in_issue_rs1_regno = 5'd6;
        alu(1'b1, 5'd6, 64'h66);
        #1;
        check("raw_wb_alu_ready", out_alu_ready, 1'b1);
        check("raw_stall_at_grant", out_issue_stall, 1'b1);
        step();
        alu(1'b0, '0, '0);
        expect_write("raw_wb", 1'b1, 5'd6, 64'h66);
        check("raw_stall_during_write", out_issue_stall, 1'b1);
        step();
        check("raw_stall_released", out_issue_stall, 1'b0);
        in_issue_valid     = 1'b0;
        in_issue_rs1_regno = 5'd0;

        // ALU write to x0: accepted, no register file write.
        alu(1'b1, 5'd0, 64'hFFFF);
        #1;
        check("x0_alu_ready", out_alu_ready, 1'b1);
        step();
        alu(1'b0, '0, '0);
        check("x0_wr_enable", out_wr_enable, 1'b0);
        check("x0_idle", out_idle, 1'b1);

        // Throughput: four back-to-back ALU writes.
        for (int k = 1; k <= 4; k++) issue(5'd0, 5'd0, regno_t'(k));
        for (int k = 1; k <= 4; k++) begin
            alu(1'b1, regno_t'(k), regval_t'(k * 17));
            #1;
            check("tput_alu_ready", out_alu_ready, 1'b1);
            step();
            expect_write("tput", 1'b1, regno_t'(k), regval_t'(k * 17));
        end
        alu(1'b0, '0, '0);
        check("tput_idle_during_last", out_idle, 1'b0);
        step();
        check("tput_wr_enable_after", out_wr_enable, 1'b0);
        check("tput_idle_after", out_idle, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule
